// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus scheduler: FSM states, the
// power-on init command ROM and clear/home command classification.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_POR,
        ST_INIT,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_GAP,
        ST_IDLE
    } lcd_state_t;

    localparam int INIT_LEN = 4;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Clear display / return home need the long settle time.
    function automatic logic is_clear_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data != 8'h00);
    endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr.
module lcd_rr_pick #(
    parameter int NREQ = 4,
    localparam int PW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic            valid
);

    logic [NREQ-1:0] elig;
    logic [PW:0]     pos;

    always_comb begin
        elig  = req & mask;
        pick  = '0;
        valid = 1'b0;
        pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, ptr} + (PW+1)'(k);
            if (pos >= (PW+1)'(NREQ))
                pos = pos - (PW+1)'(NREQ);
            if (!valid && elig[pos[PW-1:0]]) begin
                pick[pos[PW-1:0]] = 1'b1;
                valid             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Character-LCD bus owner: power-on init, E-strobe timing, settle gaps and
// round-robin/locked sharing of the bus between NREQ byte writers.
//   state | meaning
//   POR   | idle wait after reset release
//   INIT  | load next init ROM byte
//   SETUP | RS/DATA valid, E low
//   PULSE | E high
//   HOLD  | E low, RS/DATA held
//   GAP   | settle time after the write
//   IDLE  | arbitrate requesters
module lcd_bus_scheduler
    import lcd_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int POR_WAIT = 20000,
    parameter int E_SETUP  = 2,
    parameter int E_HIGH   = 4,
    parameter int E_HOLD   = 2,
    parameter int CMD_GAP  = 2000,
    parameter int CLR_GAP  = 80000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     REQ,
    input  logic [NREQ-1:0]     REQ_LOCK,
    input  logic [NREQ-1:0]     REQ_RS,
    input  logic [8*NREQ-1:0]   REQ_DATA,
    output logic [NREQ-1:0]     GNT,
    output logic                BUSY,
    output logic                INIT_DONE,
    output logic                LCD_E,
    output logic                LCD_RS,
    output logic                LCD_RW,
    output logic [7:0]          LCD_DATA
);

    localparam int CNT_MAX = (POR_WAIT > CLR_GAP) ? POR_WAIT : CLR_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(NREQ);

    localparam logic [CW-1:0] POR_LD   = CW'(POR_WAIT - 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(E_SETUP - 1);
    localparam logic [CW-1:0] HIGH_LD  = CW'(E_HIGH - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(E_HOLD - 1);
    localparam logic [CW-1:0] CMD_LD   = CW'(CMD_GAP - 1);
    localparam logic [CW-1:0] CLR_LD   = CW'(CLR_GAP - 1);

    lcd_state_t       state;
    logic [CW-1:0]    cnt;
    logic [1:0]       init_idx;
    logic [PW-1:0]    rr_ptr;
    logic             lock_valid;
    logic [PW-1:0]    lock_owner;

    logic             lock_active;
    logic [NREQ-1:0]  mask;
    logic [NREQ-1:0]  pick;
    logic             pick_valid;
    logic [PW-1:0]    pick_idx;

    // A locked owner keeps the bus even while its own REQ is low.
    assign lock_active = lock_valid && REQ_LOCK[lock_owner];
    assign mask        = lock_active ? (NREQ'(1) << lock_owner) : '1;
    assign LCD_RW      = 1'b0;

    lcd_rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (REQ),
        .mask  (mask),
        .ptr   (rr_ptr),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (pick[i]) pick_idx = PW'(i);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_POR;
            cnt        <= POR_LD;
            init_idx   <= 2'd0;
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_owner <= '0;
            GNT        <= '0;
            BUSY       <= 1'b1;
            INIT_DONE  <= 1'b0;
            LCD_E      <= 1'b0;
            LCD_RS     <= 1'b0;
            LCD_DATA   <= 8'h00;
        end else begin
            GNT <= '0;
            case (state)
                ST_POR: begin
                    if (cnt == '0) begin
                        state    <= ST_INIT;
                        init_idx <= 2'd0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_INIT: begin
                    LCD_RS   <= 1'b0;
                    LCD_DATA <= init_byte(init_idx);
                    cnt      <= SETUP_LD;
                    state    <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        LCD_E <= 1'b1;
                        cnt   <= HIGH_LD;
                        state <= ST_PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        LCD_E <= 1'b0;
                        cnt   <= HOLD_LD;
                        state <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= is_clear_cmd(LCD_RS, LCD_DATA) ? CLR_LD : CMD_LD;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (INIT_DONE || init_idx == 2'(INIT_LEN - 1)) begin
                        INIT_DONE <= 1'b1;
                        BUSY      <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        init_idx <= init_idx + 2'd1;
                        state    <= ST_INIT;
                    end
                end
                ST_IDLE: begin
                    if (lock_valid && !REQ_LOCK[lock_owner])
                        lock_valid <= 1'b0;
                    if (pick_valid) begin
                        GNT      <= pick;
                        LCD_RS   <= REQ_RS[pick_idx];
                        LCD_DATA <= REQ_DATA[{pick_idx, 3'b000} +: 8];
                        rr_ptr   <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                        if (REQ_LOCK[pick_idx]) begin
                            lock_valid <= 1'b1;
                            lock_owner <= pick_idx;
                        end
                        cnt   <= SETUP_LD;
                        BUSY  <= 1'b1;
                        state <= ST_SETUP;
                    end
                end
                default: state <= ST_POR;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Self-checking bench for lcd_bus_scheduler: init replay, single writes,
// randomized round-robin traffic, lock ownership, gap selection and reset.
module tb_lcd_bus_scheduler;

    localparam int N    = 4;
    localparam int PORW = 10;
    localparam int ES   = 1;
    localparam int EH   = 2;
    localparam int EHD  = 1;
    localparam int CG   = 4;
    localparam int CLG  = 8;
    localparam int BYTE_CYC = ES + EH + EHD;

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   REQ, REQ_LOCK, REQ_RS;
    logic [8*N-1:0] REQ_DATA;
    logic [N-1:0]   GNT;
    logic           BUSY, INIT_DONE, LCD_E, LCD_RS, LCD_RW;
    logic [7:0]     LCD_DATA;

    int errors = 0;
    int checks = 0;
    int edges  = 0;
    int gnt_pre_init = 0;

    // Behavioural model of the requesters and the arbiter's visible state.
    logic       m_req  [N];
    logic       m_lock [N];
    logic       m_rs   [N];
    logic [7:0] m_data [N];
    int         m_ptr;
    int         m_owner;
    logic [8:0] gseq [6];

    lcd_bus_scheduler #(
        .NREQ(N), .POR_WAIT(PORW), .E_SETUP(ES), .E_HIGH(EH),
        .E_HOLD(EHD), .CMD_GAP(CG), .CLR_GAP(CLG)
    ) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_LOCK(REQ_LOCK), .REQ_RS(REQ_RS),
        .REQ_DATA(REQ_DATA), .GNT(GNT), .BUSY(BUSY), .INIT_DONE(INIT_DONE),
        .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) edges <= edges + 1;
    always @(negedge CLK) if (!INIT_DONE && GNT !== '0) gnt_pre_init <= gnt_pre_init + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            REQ[i]           = m_req[i];
            REQ_LOCK[i]      = m_lock[i];
            REQ_RS[i]        = m_rs[i];
            REQ_DATA[8*i +: 8] = m_data[i];
        end
    endtask

    function automatic logic [7:0] init_ref(input int k);
        case (k)
            0:       return 8'h38;
            1:       return 8'h0C;
            2:       return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    function automatic int model_gap(input logic rs, input logic [7:0] d);
        return (!rs && d >= 8'd1 && d <= 8'd3) ? CLG : CG;
    endfunction

    function automatic logic [7:0] rand_byte();
        if ($urandom_range(0, 3) == 0) return 8'($urandom_range(1, 3));
        return 8'($urandom);
    endfunction

    function automatic int model_pick();
        bit locked;
        locked = (m_owner >= 0) && m_lock[m_owner];
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (m_req[i] && (!locked || i == m_owner)) return i;
        end
        return -1;
    endfunction

    task automatic model_grant(input int who);
        m_ptr = (who + 1) % N;
        if (m_lock[who]) m_owner = who;
        else if (m_owner >= 0 && !m_lock[m_owner]) m_owner = -1;
    endtask

    task automatic wait_rise(output int e);
        int n;
        n = 0;
        while (LCD_E !== 1'b1 && n < 200) begin @(negedge CLK); n++; end
        chk("e_rise_seen", LCD_E, 1'b1);
        e = edges;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (BUSY !== 1'b0 && n < 200) begin @(negedge CLK); n++; end
        chk("idle_reached", BUSY, 1'b0);
    endtask

    task automatic check_pulse(input string tag, input logic [7:0] d, input logic rs, output int rise);
        int w;
        w = 0;
        wait_rise(rise);
        chk({tag, "_data"}, LCD_DATA, d);
        chk({tag, "_rs"}, LCD_RS, rs);
        chk({tag, "_rw"}, LCD_RW, 1'b0);
        while (LCD_E === 1'b1 && w < 50) begin w++; @(negedge CLK); end
        chk({tag, "_width"}, w, EH);
    endtask

    task automatic check_init(input int rel, input int gbase);
        int r, prev_r, prev_gap, n;
        logic prev_busy;
        prev_r = 0;
        prev_gap = 0;
        for (int k = 0; k < 4; k++) begin
            check_pulse("init", init_ref(k), 1'b0, r);
            if (k == 0) chk("init_first_rise", r - rel, PORW + 1 + ES);
            else        chk("init_rise_spacing", r - prev_r, 1 + BYTE_CYC + prev_gap);
            prev_gap = (k == 3) ? CLG : CG;
            prev_r = r;
        end
        n = 0;
        prev_busy = BUSY;
        while (INIT_DONE !== 1'b1 && n < 100) begin
            prev_busy = BUSY;
            @(negedge CLK);
            n++;
        end
        chk("init_done_edge", edges - prev_r, EH + EHD + CLG);
        chk("busy_before_done", prev_busy, 1'b1);
        chk("busy_at_done", BUSY, 1'b0);
        chk("no_gnt_before_init", gnt_pre_init - gbase, 0);
    endtask

    // Waits for the grant the model predicts, then checks the resulting E pulse.
    task automatic serve(input string tag, output int g, output int who, output int gap);
        int n, r;
        logic [7:0] d;
        logic rs;
        who = model_pick();
        n = 0;
        while (GNT === '0 && n < 300) begin @(negedge CLK); n++; end
        chk({tag, "_gnt"}, 32'(GNT), 32'(1) << who);
        g = edges;
        d = m_data[who];
        rs = m_rs[who];
        gap = model_gap(rs, d);
        model_grant(who);
        @(negedge CLK);
        chk({tag, "_gnt_1cyc"}, GNT, '0);
        check_pulse(tag, d, rs, r);
        chk({tag, "_setup"}, r - g, ES);
    endtask

    initial begin
        int g, pg, who, gap, pgap, rel, gbase, n, r;

        gseq[0] = 9'h001; gseq[1] = 9'h141; gseq[2] = 9'h101;
        gseq[3] = 9'h141; gseq[4] = 9'h080; gseq[5] = 9'h141;
        for (int i = 0; i < N; i++) begin
            m_req[i] = 1'b0; m_lock[i] = 1'b0; m_rs[i] = 1'b0; m_data[i] = 8'h00;
        end
        m_ptr = 0;
        m_owner = -1;
        pg = 0;
        pgap = 0;
        drive();
        RST = 1'b1;

        repeat (3) @(negedge CLK);
        chk("rst_e", LCD_E, 1'b0);
        chk("rst_rs", LCD_RS, 1'b0);
        chk("rst_rw", LCD_RW, 1'b0);
        chk("rst_data", LCD_DATA, 8'h00);
        chk("rst_gnt", GNT, '0);
        chk("rst_busy", BUSY, 1'b1);
        chk("rst_init_done", INIT_DONE, 1'b0);

        gbase = gnt_pre_init;
        RST = 1'b0;
        rel = edges;
        check_init(rel, gbase);

        // single write
        m_req[2] = 1'b1; m_rs[2] = 1'b1; m_data[2] = 8'h41;
        drive();
        serve("single", g, who, gap);
        m_req[2] = 1'b0;
        drive();
        wait_idle();
        chk("single_busy_len", edges - g, BYTE_CYC + CG);

        // round robin: all four held for six grants, then random subsets
        for (int i = 0; i < N; i++) begin
            m_req[i] = 1'b1; m_rs[i] = 1'($urandom_range(0, 1)); m_data[i] = rand_byte();
        end
        drive();
        for (int k = 0; k < 16; k++) begin
            serve("rr", g, who, gap);
            if (k > 0) chk("rr_spacing", g - pg, 1 + BYTE_CYC + pgap);
            pg = g;
            pgap = gap;
            m_data[who] = rand_byte();
            m_rs[who] = 1'($urandom_range(0, 1));
            if (k >= 5) begin
                bit any;
                any = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (i == who || !m_req[i]) m_req[i] = 1'($urandom_range(0, 1));
                    if (m_req[i]) any = 1'b1;
                end
                if (!any) m_req[$urandom_range(0, N-1)] = 1'b1;
            end
            if (k == 15) for (int i = 0; i < N; i++) m_req[i] = 1'b0;
            drive();
        end
        wait_idle();

        // lock: requester 1 keeps the bus for A, B, C while requester 0 waits
        m_lock[1] = 1'b1; m_req[1] = 1'b1; m_rs[1] = 1'b1; m_data[1] = "A";
        drive();
        serve("lock_a", g, who, gap);
        m_req[1] = 1'b0; m_req[0] = 1'b1; m_rs[0] = 1'b1; m_data[0] = 8'h30;
        drive();
        n = 0;
        repeat (15) begin @(negedge CLK); if (GNT !== '0) n++; end
        chk("lock_holds_bus", n, 0);
        m_req[1] = 1'b1; m_data[1] = "B";
        drive();
        serve("lock_b", g, who, gap);
        m_data[1] = "C";
        drive();
        serve("lock_c", g, who, gap);
        pg = g;
        pgap = gap;
        m_lock[1] = 1'b0; m_req[1] = 1'b0;
        drive();
        serve("unlock", g, who, gap);
        chk("unlock_spacing", g - pg, 1 + BYTE_CYC + pgap);
        m_req[0] = 1'b0;
        drive();
        wait_idle();

        // gap selection on requester 3
        m_req[3] = 1'b1;
        {m_rs[3], m_data[3]} = gseq[0];
        drive();
        for (int k = 0; k < 6; k++) begin
            serve("gap", g, who, gap);
            if (k > 0) chk("gap_spacing", g - pg, 1 + BYTE_CYC + pgap);
            pg = g;
            pgap = gap;
            if (k < 5) {m_rs[3], m_data[3]} = gseq[k+1];
            else       m_req[3] = 1'b0;
            drive();
        end
        wait_idle();

        // reset while E is high; requester 2 keeps waiting across it
        m_req[0] = 1'b1; m_rs[0] = 1'b1; m_data[0] = 8'h5A;
        m_req[2] = 1'b1; m_rs[2] = 1'b1; m_data[2] = 8'h42;
        drive();
        who = model_pick();
        n = 0;
        while (GNT === '0 && n < 300) begin @(negedge CLK); n++; end
        chk("rst_case_gnt", 32'(GNT), 32'(1) << who);
        model_grant(who);
        m_req[who] = 1'b0;
        drive();
        wait_rise(r);
        RST = 1'b1;
        #1;
        chk("midrst_e", LCD_E, 1'b0);
        chk("midrst_gnt", GNT, '0);
        chk("midrst_init_done", INIT_DONE, 1'b0);
        chk("midrst_busy", BUSY, 1'b1);
        chk("midrst_data", LCD_DATA, 8'h00);
        m_ptr = 0;
        m_owner = -1;
        @(negedge CLK);
        gbase = gnt_pre_init;
        RST = 1'b0;
        rel = edges;
        check_init(rel, gbase);
        serve("after_rst", g, who, gap);
        m_req[who] = 1'b0;
        drive();
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
